// File: rtl/sb_pkg.sv
// Shared sideband definitions: framing symbols, CRC-16 constants and state types
// used by the sideband transmitter and the matching receiver.
package sb_pkg;

    localparam logic [7:0]  SB_DLE      = 8'hFE;
    localparam logic [7:0]  SB_ETX      = 8'h40;
    localparam logic [15:0] SB_CRC_POLY = 16'h8005;
    localparam logic [15:0] SB_CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } sb_bit_state_t;

    typedef enum logic [2:0] {
        SOF_DLE,
        SOF_STX,
        PAYLOAD,
        CRC_LO,
        CRC_HI,
        EOF_DLE,
        EOF_ETX
    } sb_byte_phase_t;

    // One serial CRC step; the incoming bit is compared against the CRC MSB.
    function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        crc16_bit = {crc[14:0], 1'b0} ^ (fb ? SB_CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sb_crc16.sv
// Combinational CRC-16 update over one byte, data bits consumed LSB first.
// Shared between the sideband transmitter and receiver.
module sb_crc16
    import sb_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);

    always_comb begin
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = crc16_bit(c, byte_in[i]);
        end
        crc_out = c;
    end

endmodule

// File: rtl/sb_transaction_tx.sv
// Sideband transaction transmitter: frames DLE/STX/payload/CRC/DLE/ETX with DLE
// stuffing and shifts each byte out as start bit, 8 data bits LSB first, stop bit.
module sb_transaction_tx
    import sb_pkg::*;
#(
    parameter int MAX_PAYLOAD = 8,
    parameter int LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                     sb_clk,
    input  logic                     rst,
    input  logic                     sb_enable,
    input  logic                     tx_req,
    input  logic [7:0]               tx_stx,
    input  logic [LEN_W-1:0]         tx_len,
    input  logic [8*MAX_PAYLOAD-1:0] tx_payload,
    output logic                     tx_ack,
    output logic                     tx_busy,
    output logic                     tx_done,
    output logic                     tx_abort,
    output logic                     sbtx
);

    sb_bit_state_t  state, state_d;
    sb_byte_phase_t phase, phase_d;

    logic [2:0]       bit_cnt, cnt_d;
    logic             stuff_q, stuff_d;
    logic [LEN_W-1:0] idx, idx_d, len_q, len_clamped, next_k;
    logic [7:0]       stx_q;
    logic [7:0]       pay_q [MAX_PAYLOAD];
    logic [15:0]      crc_q, crc_in, crc_out;
    logic [7:0]       crc_byte, cur_byte, cur_pay, next_pay;
    logic             accept, crc_step, done_d, abort_d, sbtx_d, stuffable;

    assign len_clamped = (tx_len > LEN_W'(MAX_PAYLOAD)) ? LEN_W'(MAX_PAYLOAD) : tx_len;

    // Index of the payload byte folded into the CRC while the current byte is on the line.
    assign next_k = (phase == SOF_STX) ? '0 : idx + LEN_W'(1);

    always_comb begin
        cur_pay  = '0;
        next_pay = '0;
        for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (idx == LEN_W'(i))    cur_pay  = pay_q[i];
            if (next_k == LEN_W'(i)) next_pay = pay_q[i];
        end
    end

    always_comb begin
        case (phase)
            SOF_DLE: cur_byte = SB_DLE;
            SOF_STX: cur_byte = stx_q;
            PAYLOAD: cur_byte = cur_pay;
            CRC_LO:  cur_byte = crc_q[7:0];
            CRC_HI:  cur_byte = crc_q[15:8];
            EOF_DLE: cur_byte = SB_DLE;
            EOF_ETX: cur_byte = SB_ETX;
            default: cur_byte = SB_DLE;
        endcase
    end

    assign stuffable = (phase == PAYLOAD) || (phase == CRC_LO) || (phase == CRC_HI);

    assign crc_in   = accept ? SB_CRC_INIT : crc_q;
    assign crc_byte = accept ? tx_stx : next_pay;

    sb_crc16 u_crc (
        .crc_in  (crc_in),
        .byte_in (crc_byte),
        .crc_out (crc_out)
    );

    always_comb begin
        state_d  = state;
        phase_d  = phase;
        cnt_d    = bit_cnt;
        stuff_d  = stuff_q;
        idx_d    = idx;
        accept   = 1'b0;
        crc_step = 1'b0;
        done_d   = 1'b0;
        abort_d  = 1'b0;

        if (state != IDLE && !sb_enable) begin
            state_d = IDLE;
            abort_d = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (sb_enable && tx_req) begin
                        accept  = 1'b1;
                        state_d = START;
                        phase_d = SOF_DLE;
                        stuff_d = 1'b0;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    state_d  = DATA;
                    cnt_d    = '0;
                    crc_step = !stuff_q && (phase == SOF_STX || phase == PAYLOAD)
                               && (next_k < len_q);
                end
                DATA: begin
                    if (bit_cnt == 3'd7) state_d = STOP;
                    else                 cnt_d   = bit_cnt + 3'd1;
                end
                STOP: begin
                    state_d = START;
                    if (stuffable && cur_byte == SB_DLE && !stuff_q) begin
                        stuff_d = 1'b1;
                    end else begin
                        stuff_d = 1'b0;
                        case (phase)
                            SOF_DLE: phase_d = SOF_STX;
                            SOF_STX: begin
                                if (len_q == '0) begin
                                    phase_d = CRC_LO;
                                end else begin
                                    phase_d = PAYLOAD;
                                    idx_d   = '0;
                                end
                            end
                            PAYLOAD: begin
                                if (idx == len_q - LEN_W'(1)) phase_d = CRC_LO;
                                else                          idx_d   = idx + LEN_W'(1);
                            end
                            CRC_LO:  phase_d = CRC_HI;
                            CRC_HI:  phase_d = EOF_DLE;
                            EOF_DLE: phase_d = EOF_ETX;
                            default: begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        endcase
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        case (state_d)
            IDLE:    sbtx_d = sb_enable;
            START:   sbtx_d = 1'b0;
            DATA:    sbtx_d = cur_byte[cnt_d];
            default: sbtx_d = 1'b1;
        endcase
    end

    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= SOF_DLE;
            bit_cnt  <= '0;
            stuff_q  <= 1'b0;
            idx      <= '0;
            len_q    <= '0;
            stx_q    <= '0;
            crc_q    <= SB_CRC_INIT;
            tx_ack   <= 1'b0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_abort <= 1'b0;
            sbtx     <= 1'b0;
            for (int i = 0; i < MAX_PAYLOAD; i++) pay_q[i] <= '0;
        end else begin
            state    <= state_d;
            phase    <= phase_d;
            bit_cnt  <= cnt_d;
            stuff_q  <= stuff_d;
            idx      <= idx_d;
            tx_ack   <= accept;
            tx_busy  <= (state_d != IDLE);
            tx_done  <= done_d;
            tx_abort <= abort_d;
            sbtx     <= sbtx_d;
            if (accept) begin
                stx_q <= tx_stx;
                len_q <= len_clamped;
                for (int i = 0; i < MAX_PAYLOAD; i++) pay_q[i] <= tx_payload[8*i +: 8];
            end
            if (accept || crc_step) crc_q <= crc_out;
        end
    end

endmodule

// File: tb/tb_sb_transaction_tx.sv
// Scoreboard bench for sb_transaction_tx: stimulus queues expected frames, a monitor
// deserialises sbtx after each tx_ack and compares bytes, done/abort timing and line level.
`timescale 1ns/1ps
module tb_sb_transaction_tx;

    localparam int MAXP = 8;
    localparam int LW   = 4;

    logic            sb_clk = 1'b0;
    logic            rst = 1'b1;
    logic            sb_enable = 1'b1;
    logic            tx_req = 1'b0;
    logic [7:0]      tx_stx = '0;
    logic [LW-1:0]   tx_len = '0;
    logic [8*MAXP-1:0] tx_payload = '0;
    logic tx_ack, tx_busy, tx_done, tx_abort, sbtx;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int ack_cnt = 0, end_cnt = 0, last_ack_cyc = 0, last_done_cyc = 0;

    int         exp_len_q[$];
    int         exp_abort_q[$];
    logic [7:0] exp_byte_q[$];

    sb_transaction_tx #(.MAX_PAYLOAD(MAXP)) dut (
        .sb_clk     (sb_clk),
        .rst        (rst),
        .sb_enable  (sb_enable),
        .tx_req     (tx_req),
        .tx_stx     (tx_stx),
        .tx_len     (tx_len),
        .tx_payload (tx_payload),
        .tx_ack     (tx_ack),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_abort   (tx_abort),
        .sbtx       (sbtx)
    );

    always #5 sb_clk = ~sb_clk;
    always @(posedge sb_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [7:0] stx, input int l, input logic [63:0] pl);
        logic [15:0] r;
        logic [7:0]  d;
        logic        fb;
        r = 16'hFFFF;
        for (int k = 0; k <= l; k++) begin
            d = (k == 0) ? stx : pl[8*(k-1) +: 8];
            for (int b = 0; b < 8; b++) begin
                fb = r[15] ^ d[b];
                r  = {r[14:0], 1'b0};
                if (fb) r = r ^ 16'h8005;
            end
        end
        return r;
    endfunction

    task automatic push_frame(input logic [7:0] stx, input int len, input logic [63:0] pl,
                              input int abort_at);
        logic [15:0] crc;
        logic [7:0]  b;
        int n, l;
        l   = (len > MAXP) ? MAXP : len;
        crc = crc_model(stx, l, pl);
        exp_byte_q.push_back(8'hFE);
        exp_byte_q.push_back(stx);
        n = 2;
        for (int i = 0; i < l + 2; i++) begin
            if (i < l)      b = pl[8*i +: 8];
            else if (i == l) b = crc[7:0];
            else            b = crc[15:8];
            exp_byte_q.push_back(b);
            n++;
            if (b == 8'hFE) begin
                exp_byte_q.push_back(b);
                n++;
            end
        end
        exp_byte_q.push_back(8'hFE);
        exp_byte_q.push_back(8'h40);
        n += 2;
        exp_len_q.push_back(n);
        exp_abort_q.push_back(abort_at);
    endtask

    task automatic wait_ack(input int target);
        int t = 0;
        while (ack_cnt < target && t < 400) begin
            @(negedge sb_clk);
            t++;
        end
        check("ack_wait", 32'(ack_cnt >= target), 1);
    endtask

    task automatic wait_end(input int target);
        int t = 0;
        while (end_cnt < target && t < 600) begin
            @(negedge sb_clk);
            t++;
        end
        check("end_wait", 32'(end_cnt >= target), 1);
    endtask

    task automatic drive(input logic [7:0] stx, input logic [LW-1:0] len, input logic [63:0] pl);
        tx_stx     = stx;
        tx_len     = len;
        tx_payload = pl;
    endtask

    // Monitor: after every tx_ack, capture sbtx until done/abort and score the frame.
    logic [7:0] mon_exp [0:63];
    logic       mon_bits [0:1023];
    int         mon_n, mon_ab, mon_c;
    logic [9:0] mon_got;

    initial begin : monitor
        forever begin
            @(negedge sb_clk);
            if (rst || !tx_ack) continue;
            ack_cnt++;
            last_ack_cyc = cyc;
            check("ack_expected", 32'(exp_len_q.size() > 0), 1);
            if (exp_len_q.size() == 0) continue;
            mon_n  = exp_len_q.pop_front();
            mon_ab = exp_abort_q.pop_front();
            for (int k = 0; k < mon_n; k++) mon_exp[k] = exp_byte_q.pop_front();
            mon_c = 0;
            while (!tx_done && !tx_abort && mon_c < 10 * mon_n + 5) begin
                mon_bits[mon_c] = sbtx;
                mon_c++;
                @(negedge sb_clk);
            end
            if (mon_ab < 0) begin
                check("done_cycle", 32'(mon_c), 32'(10 * mon_n));
                check("done_pulse", {31'b0, tx_done}, 1);
                check("done_line", {30'b0, sbtx, tx_busy}, 32'b10);
                for (int k = 0; k < mon_n; k++) begin
                    for (int bi = 0; bi < 10; bi++) mon_got[bi] = mon_bits[10*k + bi];
                    check("frame_byte", {22'b0, mon_got}, {22'b0, 1'b1, mon_exp[k], 1'b0});
                end
                last_done_cyc = cyc;
            end else begin
                check("abort_cycle", 32'(mon_c), 32'(mon_ab));
                check("abort_line", {28'b0, tx_abort, tx_done, tx_busy, sbtx}, 32'b1000);
                for (int k = 0; k < mon_ab / 10; k++) begin
                    for (int bi = 0; bi < 10; bi++) mon_got[bi] = mon_bits[10*k + bi];
                    check("abort_prefix", {22'b0, mon_got}, {22'b0, 1'b1, mon_exp[k], 1'b0});
                end
            end
            end_cnt++;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stimulus
        int a, e, d1, t;
        repeat (3) @(negedge sb_clk);
        check("reset_outputs", {27'b0, sbtx, tx_ack, tx_busy, tx_done, tx_abort}, 0);
        rst = 1'b0;
        @(negedge sb_clk);
        check("idle_high", {31'b0, sbtx}, 1);

        // Disabled link: line low, requests ignored.
        sb_enable = 1'b0;
        drive(8'h20, 4'd0, 64'h0);
        tx_req = 1'b1;
        @(negedge sb_clk);
        check("disabled_low", {31'b0, sbtx}, 0);
        repeat (20) @(negedge sb_clk);
        check("no_ack_disabled", 32'(ack_cnt), 0);
        tx_req = 1'b0;
        sb_enable = 1'b1;
        repeat (2) @(negedge sb_clk);

        // Minimal frame.
        a = ack_cnt; e = end_cnt;
        push_frame(8'h20, 0, 64'h0, -1);
        drive(8'h20, 4'd0, 64'h0);
        tx_req = 1'b1;
        wait_ack(a + 1);
        tx_req = 1'b0;
        @(negedge sb_clk);
        check("ack_one_cycle", {31'b0, tx_ack}, 0);
        wait_end(e + 1);
        repeat (3) @(negedge sb_clk);

        // Stuffing; inputs change after ack and must not affect the frame.
        a = ack_cnt; e = end_cnt;
        push_frame(8'h20, 3, 64'hFE00FE, -1);
        drive(8'h20, 4'd3, 64'hFE00FE);
        tx_req = 1'b1;
        wait_ack(a + 1);
        tx_req = 1'b0;
        drive(8'h99, 4'd1, 64'h0);
        wait_end(e + 1);
        repeat (3) @(negedge sb_clk);

        // Abort during the third payload byte (frame byte 4, bits 40..49).
        a = ack_cnt; e = end_cnt;
        push_frame(8'h44, 4, 64'h44332211, 45);
        drive(8'h44, 4'd4, 64'h44332211);
        tx_req = 1'b1;
        wait_ack(a + 1);
        tx_req = 1'b0;
        t = 0;
        while (cyc != last_ack_cyc + 44 && t < 200) begin
            @(negedge sb_clk);
            t++;
        end
        sb_enable = 1'b0;
        wait_end(e + 1);
        @(negedge sb_clk);
        check("abort_pulse_width", {31'b0, tx_abort}, 0);
        sb_enable = 1'b1;
        repeat (2) @(negedge sb_clk);
        check("reenable_idle", {31'b0, sbtx}, 1);

        // Fresh frame after abort.
        a = ack_cnt; e = end_cnt;
        push_frame(8'h31, 2, 64'h7EFE, -1);
        drive(8'h31, 4'd2, 64'h7EFE);
        tx_req = 1'b1;
        wait_ack(a + 1);
        tx_req = 1'b0;
        wait_end(e + 1);
        repeat (3) @(negedge sb_clk);

        // Back-to-back with tx_req held; STX changed after the first ack.
        a = ack_cnt; e = end_cnt;
        push_frame(8'h22, 1, 64'h5A, -1);
        push_frame(8'h23, 1, 64'h5A, -1);
        drive(8'h22, 4'd1, 64'h5A);
        tx_req = 1'b1;
        wait_ack(a + 1);
        tx_stx = 8'h23;
        wait_end(e + 1);
        d1 = last_done_cyc;
        wait_ack(a + 2);
        check("b2b_gap", 32'(last_ack_cyc - d1), 1);
        tx_req = 1'b0;
        wait_end(e + 2);
        repeat (3) @(negedge sb_clk);

        // Length clamp: 9 requested, 8 sent.
        a = ack_cnt; e = end_cnt;
        push_frame(8'h20, 9, 64'h0807060504030201, -1);
        drive(8'h20, 4'd9, 64'h0807060504030201);
        tx_req = 1'b1;
        wait_ack(a + 1);
        tx_req = 1'b0;
        wait_end(e + 1);
        repeat (5) @(negedge sb_clk);

        check("queue_empty", 32'(exp_len_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
